// File: rtl/pcs_66b_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : pcs_66b_pkg                                                  |
// | Purpose  : Shared 66b PCS definitions: sync-header codes, block-lock    |
// |            state encoding and the header validity check.                |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
package pcs_66b_pkg;

   // Sync-header codes; the other two codes (00, 11) never occur in a
   // correctly aligned stream.
   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   // Block-lock state machine encoding.
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      LOCKED = 2'd1,
      SLIP   = 2'd2
   } bl_state_e;

   // True for the two legal sync-header codes.
   function automatic bit sh_valid(input logic [1:0] sh);
      return (sh == SH_DATA) || (sh == SH_CTRL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hi_ber_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : hi_ber_monitor                                               |
// | Purpose  : Counts invalid sync headers over fixed periods of valid      |
// |            beats and flags a high bit-error rate.                       |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module hi_ber_monitor #(
   parameter int HIBER_WINDOW = 3125,
   parameter int HIBER_LIMIT  = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic beat,
   input  logic sh_bad,
   output logic hi_ber
);

   localparam int c_beat_w = $clog2(HIBER_WINDOW + 1);
   localparam int c_err_w  = $clog2(HIBER_LIMIT + 1);

   localparam logic [c_beat_w-1:0] c_beat_last     = c_beat_w'(HIBER_WINDOW - 1);
   localparam logic [c_err_w-1:0]  c_err_limit     = c_err_w'(HIBER_LIMIT);
   localparam logic [c_err_w-1:0]  c_err_one_short = c_err_w'(HIBER_LIMIT - 1);

   logic [c_beat_w-1:0] r_beat_cnt;
   logic [c_err_w-1:0]  r_err_cnt;
   logic                r_hi_ber;
   logic                w_limit_hit;

   // Limit is met either already or by the error on the current beat.
   assign w_limit_hit = (r_err_cnt == c_err_limit) ||
                        (sh_bad && (r_err_cnt == c_err_one_short));

   // Period counting; the flag sets as soon as the limit is met and is only
   // re-evaluated (and possibly cleared) on the last beat of a period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_beat_cnt <= '0;
         r_err_cnt  <= '0;
         r_hi_ber   <= 1'b0;
      end else if (beat) begin
         if (r_beat_cnt == c_beat_last) begin
            r_beat_cnt <= '0;
            r_err_cnt  <= '0;
            r_hi_ber   <= w_limit_hit;
         end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (sh_bad && (r_err_cnt != c_err_limit)) begin
               r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_limit_hit) begin
               r_hi_ber <= 1'b1;
            end
         end
      end
   end

   assign hi_ber = r_hi_ber;

endmodule
`default_nettype wire

// File: rtl/block_lock_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : block_lock_ctrl                                              |
// | Purpose  : 66b block-lock controller. Watches sync headers on the       |
// |            gearbox output, slips the gearbox until alignment is found,  |
// |            then holds block_lock while monitoring header errors.        |
// |            Define BLOCK_LOCK_HIBER_EN to include the hi_ber monitor;    |
// |            otherwise hi_ber is tied low.                                |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module block_lock_ctrl #(
   parameter int LOCK_CNT     = 64,
   parameter int ERR_WINDOW   = 64,
   parameter int ERR_LIMIT    = 16,
   parameter int SLIP_WAIT    = 4,
   parameter int HIBER_WINDOW = 3125,
   parameter int HIBER_LIMIT  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [65:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        slip,
   output logic        block_lock,
   output logic [15:0] sh_err_count,
   input  logic        err_count_clr,
   output logic        hi_ber
);

   import pcs_66b_pkg::*;

   localparam int c_good_w = $clog2(LOCK_CNT + 1);
   localparam int c_win_w  = $clog2(ERR_WINDOW + 1);
   localparam int c_bad_w  = $clog2(ERR_LIMIT + 1);
   localparam int c_wait_w = $clog2(SLIP_WAIT + 1);

   localparam logic [c_good_w-1:0] c_good_last = c_good_w'(LOCK_CNT - 1);
   localparam logic [c_win_w-1:0]  c_win_last  = c_win_w'(ERR_WINDOW - 1);
   localparam logic [c_bad_w-1:0]  c_bad_last  = c_bad_w'(ERR_LIMIT - 1);
   localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(SLIP_WAIT - 1);

   localparam logic [1:0] c_st_hunt   = HUNT;
   localparam logic [1:0] c_st_locked = LOCKED;
   localparam logic [1:0] c_st_slip   = SLIP;

   logic [1:0]          r_state;
   logic [c_good_w-1:0] r_good_cnt;
   logic [c_win_w-1:0]  r_win_cnt;
   logic [c_bad_w-1:0]  r_bad_cnt;
   logic [c_wait_w-1:0] r_wait_cnt;
   logic                r_slip;
   logic                r_block_lock;
   logic [15:0]         r_sh_err_count;
   logic                w_sh_ok;
   logic                w_unused_payload;

   assign w_sh_ok          = sh_valid(s_axis_tdata[65:64]);
   // Payload passes straight to the descrambler; only the header matters here.
   assign w_unused_payload = ^s_axis_tdata[63:0];

   // Lock state machine; every counter advances only on valid beats.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= c_st_hunt;
         r_good_cnt   <= '0;
         r_win_cnt    <= '0;
         r_bad_cnt    <= '0;
         r_wait_cnt   <= '0;
         r_slip       <= 1'b0;
         r_block_lock <= 1'b0;
      end else begin
         r_slip <= 1'b0;
         if (s_axis_tvalid) begin
            case (r_state)
               c_st_hunt: begin
                  if (!w_sh_ok) begin
                     r_state    <= c_st_slip;
                     r_slip     <= 1'b1;
                     r_good_cnt <= '0;
                     r_wait_cnt <= '0;
                  end else if (r_good_cnt == c_good_last) begin
                     r_state      <= c_st_locked;
                     r_block_lock <= 1'b1;
                     r_good_cnt   <= '0;
                     r_win_cnt    <= '0;
                     r_bad_cnt    <= '0;
                  end else begin
                     r_good_cnt <= r_good_cnt + 1'b1;
                  end
               end
               c_st_locked: begin
                  // The limit is tested first so that a limit-reaching error
                  // on the last beat of a window still drops lock.
                  if (!w_sh_ok && (r_bad_cnt == c_bad_last)) begin
                     r_state      <= c_st_slip;
                     r_slip       <= 1'b1;
                     r_block_lock <= 1'b0;
                     r_win_cnt    <= '0;
                     r_bad_cnt    <= '0;
                     r_wait_cnt   <= '0;
                  end else if (r_win_cnt == c_win_last) begin
                     r_win_cnt <= '0;
                     r_bad_cnt <= '0;
                  end else begin
                     r_win_cnt <= r_win_cnt + 1'b1;
                     if (!w_sh_ok) begin
                        r_bad_cnt <= r_bad_cnt + 1'b1;
                     end
                  end
               end
               c_st_slip: begin
                  // Beats still in the gearbox pipeline carry the old
                  // alignment, so their headers are not judged.
                  if (r_wait_cnt == c_wait_last) begin
                     r_state    <= c_st_hunt;
                     r_wait_cnt <= '0;
                     r_good_cnt <= '0;
                  end else begin
                     r_wait_cnt <= r_wait_cnt + 1'b1;
                  end
               end
               default: begin
                  r_state <= c_st_hunt;
               end
            endcase
         end
      end
   end

   // Saturating count of bad headers seen while locked; clear has priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sh_err_count <= '0;
      end else if (err_count_clr) begin
         r_sh_err_count <= '0;
      end else if (s_axis_tvalid && !w_sh_ok && r_block_lock &&
                   (r_sh_err_count != 16'hFFFF)) begin
         r_sh_err_count <= r_sh_err_count + 16'd1;
      end
   end

   assign slip         = r_slip;
   assign block_lock   = r_block_lock;
   assign sh_err_count = r_sh_err_count;

`ifdef BLOCK_LOCK_HIBER_EN
   logic w_sh_bad;

   assign w_sh_bad = s_axis_tvalid && !w_sh_ok;

   hi_ber_monitor #(
      .HIBER_WINDOW (HIBER_WINDOW),
      .HIBER_LIMIT  (HIBER_LIMIT)
   ) u_hi_ber_monitor (
      .clk    (clk),
      .reset  (reset),
      .beat   (s_axis_tvalid),
      .sh_bad (w_sh_bad),
      .hi_ber (hi_ber)
   );
`else
   // Monitor not built; its configuration is retained but has no effect.
   localparam int c_unused_hiber_cfg = HIBER_WINDOW + HIBER_LIMIT;

   assign hi_ber = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_lock_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_block_lock_ctrl                                           |
// | Purpose  : Scoreboard bench for block_lock_ctrl. Each driven cycle      |
// |            queues the expected registered outputs; a monitor pops and   |
// |            compares one cycle later. With BLOCK_LOCK_HIBER_EN the       |
// |            hi_ber scenario also runs.                                   |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module tb_block_lock_ctrl;

   logic        clk;
   logic        reset;
   logic [65:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        slip;
   logic        block_lock;
   logic [15:0] sh_err_count;
   logic        err_count_clr;
   logic        hi_ber;

   block_lock_ctrl #(
      .LOCK_CNT     (64),
      .ERR_WINDOW   (64),
      .ERR_LIMIT    (16),
      .SLIP_WAIT    (4),
      .HIBER_WINDOW (100),
      .HIBER_LIMIT  (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .slip          (slip),
      .block_lock    (block_lock),
      .sh_err_count  (sh_err_count),
      .err_count_clr (err_count_clr),
      .hi_ber        (hi_ber)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      bit          slip;
      bit          lock;
      logic [15:0] err;
      bit          hib;
      bit          hib_chk;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Current expected output levels, maintained by the scenarios.
   bit          el;
   logic [15:0] ee;
   bit          eh;
   bit          hib_chk;

   localparam logic [1:0] SHD = 2'b01;
   localparam logic [1:0] SHC = 2'b10;
   localparam logic [1:0] SB0 = 2'b00;
   localparam logic [1:0] SB3 = 2'b11;

   // Monitor: compares the outputs registered at this edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if ((slip !== e.slip) || (block_lock !== e.lock) ||
             (sh_err_count !== e.err) || (e.hib_chk && (hi_ber !== e.hib))) begin
            errors++;
            $display("FAIL %s: got slip=%0b lock=%0b err=%0d hi_ber=%0b, expected slip=%0b lock=%0b err=%0d hi_ber=%0b(chk=%0b) t=%0t",
                     e.tag, slip, block_lock, sh_err_count, hi_ber,
                     e.slip, e.lock, e.err, e.hib, e.hib_chk, $time);
         end
      end
   end

   // One driven cycle plus the outputs expected after the following edge.
   task automatic step(input bit rst, input bit v, input logic [1:0] sh,
                       input bit clr, input bit xs, input string tag);
      exp_t e;
      @(negedge clk);
      reset         = rst;
      s_axis_tvalid = v;
      s_axis_tdata  = {sh, $urandom(), $urandom()};
      err_count_clr = clr;
      e.tag     = tag;
      e.slip    = xs;
      e.lock    = el;
      e.err     = ee;
      e.hib     = eh;
      e.hib_chk = hib_chk;
      q.push_back(e);
   endtask

   task automatic beat(input logic [1:0] sh, input bit clr, input bit xs, input string tag);
      step(1'b0, 1'b1, sh, clr, xs, tag);
   endtask

   // Idle cycle carrying a garbage header that must be ignored.
   task automatic idle(input string tag);
      step(1'b0, 1'b0, SB3, 1'b0, 1'b0, tag);
   endtask

   task automatic do_reset(input string tag);
      el = 1'b0; ee = 16'd0; eh = 1'b0;
      step(1'b1, 1'b0, SHD, 1'b0, 1'b0, tag);
      step(1'b1, 1'b1, SB3, 1'b0, 1'b0, tag);
      step(1'b0, 1'b0, SB3, 1'b0, 1'b0, tag);
   endtask

   task automatic gaps();
      int n;
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) idle("gap_idle");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset         = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      err_count_clr = 1'b0;
      el = 1'b0; ee = 16'd0; eh = 1'b0;
      hib_chk = 1'b1;
`ifdef BLOCK_LOCK_HIBER_EN
      // hi_ber over the mixed scenarios is checked only in its own scenario.
      hib_chk = 1'b0;
`endif

      do_reset("reset_state");

      // Acquire lock with alternating legal headers.
      for (int i = 1; i <= 64; i++) begin
         el = (i == 64);
         beat((i % 2) ? SHD : SHC, 1'b0, 1'b0, "acquire");
      end
      for (int i = 1; i <= 4; i++) beat(SHD, 1'b0, 1'b0, "hold_lock");

      // Slip during hunt one beat short of lock.
      do_reset("reset_before_hunt");
      for (int i = 1; i <= 63; i++) beat(SHD, 1'b0, 1'b0, "hunt_good");
      beat(SB3, 1'b0, 1'b1, "hunt_slip");
      for (int i = 1; i <= 4; i++) beat(SB0, 1'b0, 1'b0, "slip_wait_ignored");
      for (int i = 1; i <= 64; i++) begin
         el = (i == 64);
         beat(SHC, 1'b0, 1'b0, "relock");
      end

      // Loss of lock: 16 bad headers inside one window.
      for (int i = 1; i <= 16; i++) begin
         ee = 16'(i);
         el = (i < 16);
         beat(SB0, 1'b0, (i == 16), "loss_of_lock");
      end
      ee = 16'd0;
      beat(SB0, 1'b1, 1'b0, "clr_in_slip");
      for (int i = 1; i <= 3; i++) beat(SB3, 1'b0, 1'b0, "slip_wait_unlocked");
      for (int i = 1; i <= 64; i++) begin
         el = (i == 64);
         beat(SHD, 1'b0, 1'b0, "relock2");
      end

      // Three windows with 15 bad headers each: lock holds, count reaches 45.
      for (int w = 0; w < 3; w++) begin
         for (int j = 1; j <= 64; j++) begin
            if (j <= 15) ee = ee + 16'd1;
            beat((j <= 15) ? SB0 : SHD, 1'b0, 1'b0, (j <= 15) ? "window_bad" : "window_good");
         end
      end
      // Clear coincident with a bad header: count goes to 0, error not counted.
      ee = 16'd0;
      beat(SB0, 1'b1, 1'b0, "clr_vs_err");
      for (int j = 2; j <= 49; j++) beat(SHD, 1'b0, 1'b0, "win4_good");
      // Limit reached on the very last beat of the window.
      for (int j = 50; j <= 64; j++) begin
         ee = ee + 16'd1;
         if (j == 64) el = 1'b0;
         beat(SB0, 1'b0, (j == 64), "limit_at_window_end");
      end

      // Idle gaps: ignored slip beats, partial hunt, then reset mid-hunt.
      for (int i = 1; i <= 4; i++) begin
         gaps();
         beat(SHD, 1'b0, 1'b0, "gap_slip_wait");
      end
      for (int i = 1; i <= 30; i++) begin
         gaps();
         beat(SHD, 1'b0, 1'b0, "gap_hunt");
      end
      do_reset("reset_mid_hunt");
      for (int i = 1; i <= 64; i++) begin
         gaps();
         el = (i == 64);
         beat(SHD, 1'b0, 1'b0, "gap_lock");
      end
      idle("gap_after_lock");

`ifdef BLOCK_LOCK_HIBER_EN
      // BER: 16 bad headers in period 1, clean period 2.
      do_reset("reset_ber");
      hib_chk = 1'b1;
      for (int b = 1; b <= 201; b++) begin
         el = ((b >= 64) && (b < 80)) || (b >= 148);
         ee = (b < 65) ? 16'd0 : ((b <= 80) ? 16'(b - 64) : 16'd16);
         eh = (b >= 80) && (b < 200);
         beat(((b >= 65) && (b <= 80)) ? SB0 : SHD, 1'b0, (b == 80), "hi_ber");
      end
`endif

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
